// File: rtl/swd_pkg.sv
// Shared types and constants for the multi-channel SWD frame engine.
package swd_pkg;

   typedef enum logic [3:0] {
      ST_IDLE,
      ST_PAD,
      ST_REQ,
      ST_TURN1,
      ST_ACK,
      ST_RDATA,
      ST_RPAR,
      ST_TURN2,
      ST_WDATA,
      ST_WPAR,
      ST_TAIL
   } swd_state_t;

   localparam logic [2:0] ACK_OK    = 3'b001;
   localparam logic [2:0] ACK_WAIT  = 3'b010;
   localparam logic [2:0] ACK_FAULT = 3'b100;

   localparam int REQ_BITS = 8;
   localparam int ACK_BITS = 3;

   // Phases in which the selected target owns swdio and the host listens on miso.
   function automatic logic f_is_target(swd_state_t s);
      return (s == ST_ACK) || (s == ST_RDATA) || (s == ST_RPAR);
   endfunction

endpackage

// File: rtl/swd_parity_acc.sv
// Running XOR of a serial bit stream; cleared per frame, shared by read check and write generation.
module swd_parity_acc (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_clr,
   input  logic i_en,
   input  logic i_bit,
   output logic o_par
);

   logic r_par;

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst)
         r_par <= 1'b0;
      else if (i_clr)
         r_par <= 1'b0;
      else if (i_en)
         r_par <= r_par ^ i_bit;
   end

   assign o_par = r_par;

endmodule

// File: rtl/swd_frame_engine_mc.sv
// SPI-host to multi-target SWD frame engine: request/ACK/data/parity sequencing with
// WAIT/FAULT abort, read parity check and per-channel clock gating.
module swd_frame_engine_mc
   import swd_pkg::*;
#(
   parameter int  NUM_CH   = 2,
   parameter int  DATA_W   = 32,
   parameter int  PAD_BITS = 2,
   parameter int  TURN_CYC = 1,
   parameter int  GEN_WPAR = 1,
   localparam int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              i_sck,
   input  logic              i_rst,
   input  logic              i_mosi,
   output logic              o_miso,
   output logic              o_miso_oe,
   input  logic              i_start,
   input  logic              i_rnw,
   input  logic              i_raw_en,
   input  logic [CH_W-1:0]   i_ch_sel,
   output logic [NUM_CH-1:0] o_swclk,
   output logic [NUM_CH-1:0] o_swdio_o,
   output logic [NUM_CH-1:0] o_swdio_oe,
   input  logic [NUM_CH-1:0] i_swdio_i,
   output logic              o_busy,
   output logic              o_frame_done,
   output logic [2:0]        o_ack,
   output logic [DATA_W-1:0] o_rd_data,
   output logic              o_par_err,
   output logic              o_sel_err
);

   localparam int            CNT_W  = $clog2(DATA_W + 1);
   localparam logic [CH_W:0] CH_LIM = NUM_CH[CH_W:0];

   swd_state_t        r_state;
   swd_state_t        w_nxt;
   logic [CNT_W-1:0]  r_cnt;
   logic [CH_W-1:0]   r_ch;
   logic              r_rnw;
   logic [2:0]        r_ack;
   logic [DATA_W-1:0] r_rd_data;
   logic              r_par_err;
   logic              r_sel_err;

   logic              w_last;
   logic              w_sel_bad;
   logic              w_start_ok;
   logic              w_tbit;
   logic [2:0]        w_ack_full;
   logic              w_par;
   logic              w_host_drv;
   logic              w_host_bit;

   // Counter reload value on entry to a state: phase length minus one.
   function automatic logic [CNT_W-1:0] f_len(swd_state_t s);
      case (s)
         ST_PAD:             f_len = CNT_W'(PAD_BITS - 1);
         ST_REQ:             f_len = CNT_W'(REQ_BITS - 1);
         ST_TURN1, ST_TURN2: f_len = CNT_W'(TURN_CYC - 1);
         ST_ACK:             f_len = CNT_W'(ACK_BITS - 1);
         ST_RDATA, ST_WDATA: f_len = CNT_W'(DATA_W - 1);
         default:            f_len = '0;
      endcase
   endfunction

   assign w_last     = (r_cnt == '0);
   assign w_sel_bad  = ({1'b0, i_ch_sel} >= CH_LIM);
   assign w_start_ok = (r_state == ST_IDLE) && i_start && !w_sel_bad;
   assign w_tbit     = i_swdio_i[r_ch];
   assign w_ack_full = {w_tbit, r_ack[2:1]};

   always_comb begin
      w_nxt = r_state;
      case (r_state)
         ST_IDLE:  if (w_start_ok) w_nxt = (PAD_BITS > 0) ? ST_PAD : ST_REQ;
         ST_PAD:   if (w_last) w_nxt = ST_REQ;
         ST_REQ:   if (w_last) w_nxt = ST_TURN1;
         ST_TURN1: if (w_last) w_nxt = ST_ACK;
         ST_ACK: begin
            if (w_last) begin
               case (w_ack_full)
                  ACK_OK:              w_nxt = r_rnw ? ST_RDATA : ST_TURN2;
                  ACK_WAIT, ACK_FAULT: w_nxt = ST_TURN2;
                  default:             w_nxt = ST_TURN2;
               endcase
            end
         end
         ST_RDATA: if (w_last) w_nxt = ST_RPAR;
         ST_RPAR:  w_nxt = ST_TURN2;
         // A write with a good ACK is the only path that carries data after TURN2.
         ST_TURN2: if (w_last) w_nxt = (!r_rnw && (r_ack == ACK_OK)) ? ST_WDATA : ST_TAIL;
         ST_WDATA: if (w_last) w_nxt = ST_WPAR;
         ST_WPAR:  w_nxt = ST_TAIL;
         ST_TAIL:  w_nxt = ST_IDLE;
         default:  w_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge i_sck or posedge i_rst) begin
      if (i_rst) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
      end else begin
         r_state <= w_nxt;
         if (w_nxt != r_state)
            r_cnt <= f_len(w_nxt);
         else if (!w_last)
            r_cnt <= r_cnt - 1'b1;
      end
   end

   always_ff @(posedge i_sck or posedge i_rst) begin
      if (i_rst) begin
         r_ch      <= '0;
         r_rnw     <= 1'b0;
         r_ack     <= '0;
         r_rd_data <= '0;
         r_par_err <= 1'b0;
         r_sel_err <= 1'b0;
      end else begin
         r_sel_err <= (r_state == ST_IDLE) && i_start && w_sel_bad;
         if (w_start_ok) begin
            r_ch      <= i_ch_sel;
            r_rnw     <= i_rnw;
            r_par_err <= 1'b0;
         end
         if (r_state == ST_ACK)
            r_ack <= w_ack_full;
         if (r_state == ST_RDATA)
            r_rd_data <= {w_tbit, r_rd_data[DATA_W-1:1]};
         if (r_state == ST_RPAR)
            r_par_err <= w_tbit ^ w_par;
      end
   end

   swd_parity_acc u_par (
      .i_clk (i_sck),
      .i_rst (i_rst),
      .i_clr (w_start_ok),
      .i_en  ((r_state == ST_RDATA) || (r_state == ST_WDATA)),
      .i_bit ((r_state == ST_RDATA) ? w_tbit : i_mosi),
      .o_par (w_par)
   );

   always_comb begin
      o_swdio_oe = '0;
      o_swdio_o  = '0;
      o_swclk    = '0;
      o_miso     = 1'b0;
      o_miso_oe  = 1'b0;
      w_host_drv = 1'b0;
      w_host_bit = i_mosi;
      case (r_state)
         ST_PAD:            begin w_host_drv = 1'b1; w_host_bit = 1'b0; end
         ST_REQ, ST_WDATA:  w_host_drv = 1'b1;
         ST_WPAR: begin
            w_host_drv = 1'b1;
            w_host_bit = (GEN_WPAR != 0) ? w_par : i_mosi;
         end
         default: ;
      endcase
      if (r_state == ST_IDLE) begin
         // Raw pass-through follows the live ch_sel; a start in the same cycle takes priority.
         if (i_raw_en && !i_start && !w_sel_bad) begin
            o_swdio_oe[i_ch_sel] = 1'b1;
            o_swdio_o[i_ch_sel]  = i_mosi;
            o_swclk[i_ch_sel]    = i_sck;
         end
      end else begin
         o_swclk[r_ch]    = i_sck;
         o_swdio_oe[r_ch] = w_host_drv;
         o_swdio_o[r_ch]  = w_host_drv & w_host_bit;
      end
      if (f_is_target(r_state)) begin
         o_miso_oe = 1'b1;
         o_miso    = w_tbit;
      end
   end

   assign o_busy       = (r_state != ST_IDLE);
   assign o_frame_done = (r_state == ST_TAIL);
   assign o_ack        = r_ack;
   assign o_rd_data    = r_rd_data;
   assign o_par_err    = r_par_err;
   assign o_sel_err    = r_sel_err;

endmodule

// File: tb/tb_swd_frame_engine_mc.sv
// Randomized self-checking bench: a phase-list model of each frame drives and checks the engine.
module tb_swd_frame_engine_mc;
   import swd_pkg::*;

   localparam int NCH  = 2;
   localparam int DW   = 32;
   localparam int PADB = 2;
   localparam int TC   = 1;
   localparam int GW   = 1;
   localparam int LEN_FULL  = PADB + 8 + 2*TC + 3 + DW + 1 + 1;
   localparam int LEN_ABORT = PADB + 8 + 2*TC + 3 + 1;

   typedef enum {P_PAD, P_REQ, P_TURN, P_ACK, P_RD, P_RP, P_WD, P_WP, P_TAIL} ph_e;

   logic           i_sck = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_mosi = 1'b0;
   logic           i_start = 1'b0;
   logic           i_rnw = 1'b0;
   logic           i_raw_en = 1'b0;
   logic [0:0]     i_ch_sel = '0;
   logic [NCH-1:0] i_swdio_i = '0;
   logic           o_miso, o_miso_oe, o_busy, o_frame_done, o_par_err, o_sel_err;
   logic [NCH-1:0] o_swclk, o_swdio_o, o_swdio_oe;
   logic [2:0]     o_ack;
   logic [DW-1:0]  o_rd_data;

   int            total = 0;
   int            bad = 0;
   logic [DW-1:0] g_rd = '0;

   swd_frame_engine_mc #(
      .NUM_CH(NCH), .DATA_W(DW), .PAD_BITS(PADB), .TURN_CYC(TC), .GEN_WPAR(GW)
   ) dut (
      .i_sck(i_sck), .i_rst(i_rst), .i_mosi(i_mosi), .o_miso(o_miso), .o_miso_oe(o_miso_oe),
      .i_start(i_start), .i_rnw(i_rnw), .i_raw_en(i_raw_en), .i_ch_sel(i_ch_sel),
      .o_swclk(o_swclk), .o_swdio_o(o_swdio_o), .o_swdio_oe(o_swdio_oe), .i_swdio_i(i_swdio_i),
      .o_busy(o_busy), .o_frame_done(o_frame_done), .o_ack(o_ack), .o_rd_data(o_rd_data),
      .o_par_err(o_par_err), .o_sel_err(o_sel_err)
   );

   always #5 i_sck = ~i_sck;

   // Drives one frame cycle by cycle from its phase list and checks every cycle.
   task automatic run_frame(input int ch, input bit rnw, input logic [7:0] req,
                            input logic [2:0] ackv, input logic [DW-1:0] data, input bit pflip,
                            input bit noisy, input int rst_at, output int done_idx);
      ph_e           seq[$];
      bit            ok;
      int            rq, ai, di, n;
      logic          host, tgt, e_o, e_miso;
      logic [7:0]    e_v, o_v;
      logic [DW-1:0] e_rd;
      ok = (ackv == ACK_OK);
      for (int k = 0; k < PADB; k++) seq.push_back(P_PAD);
      for (int k = 0; k < 8; k++)    seq.push_back(P_REQ);
      for (int k = 0; k < TC; k++)   seq.push_back(P_TURN);
      for (int k = 0; k < 3; k++)    seq.push_back(P_ACK);
      if (ok && rnw) begin
         for (int k = 0; k < DW; k++) seq.push_back(P_RD);
         seq.push_back(P_RP);
         for (int k = 0; k < TC; k++) seq.push_back(P_TURN);
      end else if (ok) begin
         for (int k = 0; k < TC; k++) seq.push_back(P_TURN);
         for (int k = 0; k < DW; k++) seq.push_back(P_WD);
         seq.push_back(P_WP);
      end else begin
         for (int k = 0; k < TC; k++) seq.push_back(P_TURN);
      end
      seq.push_back(P_TAIL);
      n = seq.size();
      rq = 0; ai = 0; di = 0; done_idx = -1;

      @(negedge i_sck);
      i_start = 1'b1; i_rnw = rnw; i_ch_sel = 1'(ch); i_raw_en = 1'b1;
      i_mosi = 1'($urandom); i_swdio_i = NCH'($urandom);
      #1;
      total++;
      if (o_swdio_oe !== '0 || o_busy !== 1'b0) begin
         bad++;
         $display("FAIL start_over_raw: oe=%b busy=%b need oe=00 busy=0", o_swdio_oe, o_busy);
      end

      for (int c = 0; c < n; c++) begin
         @(negedge i_sck);
         i_start  = (noisy && c != n - 1) ? 1'($urandom) : 1'b0;
         i_raw_en = noisy ? 1'($urandom) : 1'b0;
         if (noisy) begin
            i_rnw    = 1'($urandom);
            i_ch_sel = 1'($urandom);
         end
         i_mosi    = 1'($urandom);
         i_swdio_i = NCH'($urandom);
         host = 1'b0; tgt = 1'b0; e_o = 1'b0;
         case (seq[c])
            P_PAD: host = 1'b1;
            P_REQ: begin host = 1'b1; i_mosi = req[rq]; e_o = req[rq]; rq++; end
            P_WD:  begin host = 1'b1; i_mosi = data[di]; e_o = data[di]; di++; end
            P_WP:  begin host = 1'b1; e_o = (GW != 0) ? ^data : i_mosi; end
            P_ACK: begin tgt = 1'b1; i_swdio_i[ch] = ackv[ai]; ai++; end
            P_RD:  begin tgt = 1'b1; i_swdio_i[ch] = data[di]; di++; end
            P_RP:  begin tgt = 1'b1; i_swdio_i[ch] = (^data) ^ pflip; end
            default: ;
         endcase
         e_miso = i_swdio_i[ch];
         #1;
         e_v = {NCH'(host) << ch, e_o, tgt, tgt ? e_miso : 1'b0, 1'b1, (c == n - 1), 1'b0};
         o_v = {o_swdio_oe, host ? o_swdio_o[ch] : 1'b0, o_miso_oe, tgt ? o_miso : 1'b0,
                o_busy, o_frame_done, o_sel_err};
         total++;
         if (o_v !== e_v) begin
            bad++;
            $display("FAIL frame_cycle c=%0d phase=%s {oe,o,moe,miso,busy,done,sel} got=%b need=%b",
                     c, seq[c].name(), o_v, e_v);
         end
         if (o_frame_done === 1'b1) done_idx = c;
         if (c == rst_at) begin
            i_rst = 1'b1;
            #1;
            total++;
            if ({o_swdio_oe, o_miso_oe, o_busy, o_frame_done} !== 5'b0) begin
               bad++;
               $display("FAIL async_reset: oe=%b moe=%b busy=%b done=%b need all 0",
                        o_swdio_oe, o_miso_oe, o_busy, o_frame_done);
            end
            return;
         end
         if (c == n - 1) begin
            e_rd = (rnw && ok) ? data : g_rd;
            total++;
            if (o_ack !== ackv) begin
               bad++; $display("FAIL ack: got=%b need=%b", o_ack, ackv);
            end
            total++;
            if (o_rd_data !== e_rd) begin
               bad++; $display("FAIL rd_data: got=%h need=%h", o_rd_data, e_rd);
            end
            total++;
            if (o_par_err !== 1'(rnw && ok && pflip)) begin
               bad++; $display("FAIL par_err: got=%b need=%b", o_par_err, rnw && ok && pflip);
            end
            g_rd = e_rd;
         end
      end
      @(negedge i_sck);
      i_start = 1'b0; i_raw_en = 1'b0; i_mosi = 1'b0;
      #1;
      total++;
      if (o_busy !== 1'b0 || o_swdio_oe !== '0) begin
         bad++; $display("FAIL idle_after: busy=%b oe=%b need 0/00", o_busy, o_swdio_oe);
      end
   endtask

   task automatic test_reset();
      i_rst = 1'b1;
      repeat (2) @(negedge i_sck);
      #1;
      total++;
      if (o_swdio_oe !== '0 || o_swdio_o !== '0 || o_swclk !== '0) begin
         bad++; $display("FAIL reset_pads: oe=%b o=%b clk=%b need 0", o_swdio_oe, o_swdio_o, o_swclk);
      end
      total++;
      if (o_miso !== 1'b0 || o_miso_oe !== 1'b0) begin
         bad++; $display("FAIL reset_miso: miso=%b moe=%b need 0", o_miso, o_miso_oe);
      end
      total++;
      if ({o_busy, o_frame_done, o_par_err, o_sel_err} !== 4'b0) begin
         bad++; $display("FAIL reset_flags: got=%b need=0000", {o_busy, o_frame_done, o_par_err, o_sel_err});
      end
      total++;
      if (o_ack !== 3'b0 || o_rd_data !== '0) begin
         bad++; $display("FAIL reset_capture: ack=%b rd=%h need 0", o_ack, o_rd_data);
      end
      @(negedge i_sck);
      i_rst = 1'b0;
   endtask

   task automatic test_raw();
      logic [15:0] pat;
      pat = 16'hA5C3;
      for (int b = 0; b < 16; b++) begin
         @(negedge i_sck);
         i_start = 1'b0; i_raw_en = 1'b1; i_ch_sel = 1'b0; i_mosi = pat[b];
         i_swdio_i = NCH'($urandom);
         #1;
         total++;
         if ({o_swdio_oe, o_swdio_o[0], o_miso_oe, o_swclk, o_busy} !== {2'b01, pat[b], 1'b0, 2'b00, 1'b0}) begin
            bad++;
            $display("FAIL raw_low b=%0d: got oe=%b o0=%b moe=%b clk=%b busy=%b need oe=01 o0=%b moe=0 clk=00 busy=0",
                     b, o_swdio_oe, o_swdio_o[0], o_miso_oe, o_swclk, o_busy, pat[b]);
         end
         @(posedge i_sck);
         #1;
         total++;
         if (o_swclk !== 2'b01) begin
            bad++; $display("FAIL raw_swclk b=%0d: got=%b need=01", b, o_swclk);
         end
      end
      @(negedge i_sck);
      i_raw_en = 1'b0;
   endtask

   task automatic test_read_good();
      int d;
      run_frame(0, 1'b1, 8'hA5, ACK_OK, 32'h12345678, 1'b0, 1'b0, -1, d);
      total++;
      if (d !== 48) begin bad++; $display("FAIL read_done_cycle: got=%0d need=48", d); end
   endtask

   task automatic test_read_badpar();
      int d;
      run_frame(0, 1'b1, 8'hA5, ACK_OK, 32'h12345678, 1'b1, 1'b0, -1, d);
      total++;
      if (d !== LEN_FULL - 1) begin bad++; $display("FAIL badpar_done_cycle: got=%0d need=%0d", d, LEN_FULL - 1); end
   endtask

   task automatic test_read_wait();
      int d;
      run_frame(0, 1'b1, 8'hA5, ACK_WAIT, 32'hCAFEF00D, 1'b0, 1'b0, -1, d);
      total++;
      if (d !== 15) begin bad++; $display("FAIL wait_done_cycle: got=%0d need=15", d); end
   endtask

   task automatic test_write();
      int d;
      run_frame(1, 1'b0, 8'h81, ACK_OK, 32'hDEADBEEF, 1'b0, 1'b0, -1, d);
      total++;
      if (d !== 48) begin bad++; $display("FAIL write_done_cycle: got=%0d need=48", d); end
      run_frame(1, 1'b0, 8'h99, ACK_FAULT, 32'h0BADF00D, 1'b0, 1'b0, -1, d);
      total++;
      if (d !== LEN_ABORT - 1) begin bad++; $display("FAIL fault_done_cycle: got=%0d need=%0d", d, LEN_ABORT - 1); end
   endtask

   task automatic test_random();
      int d, sel;
      logic [2:0] a;
      for (int i = 0; i < 24; i++) begin
         sel = int'($urandom_range(0, 9));
         a = (sel < 6) ? ACK_OK : (sel < 7) ? ACK_WAIT : (sel < 8) ? ACK_FAULT : 3'($urandom);
         run_frame(int'($urandom_range(0, NCH - 1)), 1'($urandom), 8'($urandom), a, DW'($urandom),
                   1'($urandom), 1'b1, -1, d);
         total++;
         if (d !== ((a == ACK_OK) ? LEN_FULL - 1 : LEN_ABORT - 1)) begin
            bad++; $display("FAIL rand_done_cycle i=%0d ack=%b: got=%0d", i, a, d);
         end
      end
   endtask

   task automatic test_back_to_back();
      int d;
      for (int i = 0; i < 3; i++) begin
         run_frame(i % NCH, 1'(i), 8'($urandom), ACK_OK, DW'($urandom), 1'b0, 1'b0, -1, d);
         total++;
         if (d !== LEN_FULL - 1) begin bad++; $display("FAIL b2b_done_cycle i=%0d: got=%0d", i, d); end
      end
   endtask

   task automatic test_reset_mid();
      int d;
      run_frame(0, 1'b1, 8'hA5, ACK_OK, 32'h55AA33CC, 1'b0, 1'b0, PADB + 8 + TC + 3 + 10, d);
      @(negedge i_sck);
      @(negedge i_sck);
      i_rst = 1'b0;
      g_rd = '0;
      run_frame(1, 1'b1, 8'hA5, ACK_OK, 32'h0F1E2D3C, 1'b0, 1'b0, -1, d);
      total++;
      if (d !== LEN_FULL - 1) begin bad++; $display("FAIL post_reset_done_cycle: got=%0d need=%0d", d, LEN_FULL - 1); end
   endtask

   initial begin
      test_reset();
      test_raw();
      test_read_good();
      test_read_badpar();
      test_read_wait();
      test_write();
      test_random();
      test_back_to_back();
      test_reset_mid();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
